// File: rtl/secded_pkg.sv
// Shared widths and types for the SECDED error monitor and its error-log FIFO.
package secded_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CODE_W     = 72;
  localparam int unsigned CHK_W      = 8;
  localparam int unsigned LOG_ADDR_W = 32;

  typedef struct packed {
    logic [LOG_ADDR_W-1:0] addr;
    logic                  dbl;
  } err_log_entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              poison;
  } skid_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/secded_log_fifo.sv
// Generic synchronous circular FIFO; a push into a full FIFO is dropped unless a pop happens the same cycle.
module secded_log_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];

  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PTR_W'(1);
    if (pop_ok)  rd_d = rd_q + PTR_W'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok) mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/secded_err_monitor.sv
// Consumes SECDED decoder outputs: forwards corrected data through a 2-entry skid buffer,
// counts single/double errors, logs erroneous addresses and raises a sticky interrupt.
module secded_err_monitor
  import secded_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOG_DEPTH = 4,
  parameter int unsigned SE_THRESH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [CODE_W-1:0] D_DATA,
  input  logic              ERR,
  input  logic              S_ERR,
  input  logic              D_ERR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_POISON,
  output logic [CNT_W-1:0]  SE_CNT,
  output logic [CNT_W-1:0]  DE_CNT,
  output logic              LOG_VALID,
  input  logic              LOG_READY,
  output logic [ADDR_W-1:0] LOG_ADDR,
  output logic              LOG_DBL,
  output logic              LOG_OVF,
  output logic              IRQ,
  input  logic              CLR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  skid_state_e    state_q, state_d;
  skid_entry_t    head_q, head_d;
  skid_entry_t    tail_q, tail_d;
  skid_entry_t    in_word;
  logic           accept;
  logic           pop;

  logic [CNT_W-1:0] se_q, se_d, se_base;
  logic [CNT_W-1:0] de_q, de_d, de_base;
  logic             se_inc, de_inc;
  logic             irq_q, irq_d, irq_set;
  logic             ovf_q, ovf_d, ovf_set;

  err_log_entry_t log_wdata;
  err_log_entry_t log_head;
  logic           log_push, log_pop, log_full, log_empty;

  // Check bits are already consumed by the decoder; only the data half travels on.
  logic unused_chk;
  assign unused_chk = ^D_DATA[CODE_W-1:DATA_W];

  assign IN_READY   = (state_q != TWO);
  assign OUT_VALID  = (state_q != EMPTY);
  assign OUT_DATA   = head_q.data;
  assign OUT_POISON = head_q.poison;

  assign accept         = IN_VALID & IN_READY;
  assign pop            = OUT_VALID & OUT_READY;
  assign in_word.data   = D_DATA[DATA_W-1:0];
  assign in_word.poison = D_ERR;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_word;
        end else if (accept) begin
          tail_d  = in_word;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // CLR zeroes the base value first so a same-cycle event still lands.
  assign se_inc  = accept & S_ERR;
  assign de_inc  = accept & D_ERR;
  assign se_base = CLR ? '0 : se_q;
  assign de_base = CLR ? '0 : de_q;
  assign se_d    = (se_inc && se_base != CNT_MAX) ? se_base + CNT_W'(1) : se_base;
  assign de_d    = (de_inc && de_base != CNT_MAX) ? de_base + CNT_W'(1) : de_base;

  assign irq_set = de_inc | (se_inc & (se_base == CNT_W'(SE_THRESH - 1)));
  assign irq_d   = (irq_q & ~CLR) | irq_set;

  assign log_push       = accept & ERR;
  assign log_pop        = LOG_VALID & LOG_READY;
  assign log_wdata.addr = LOG_ADDR_W'(IN_ADDR);
  assign log_wdata.dbl  = D_ERR;
  assign ovf_set        = log_push & log_full & ~log_pop;
  assign ovf_d          = (ovf_q & ~CLR) | ovf_set;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      se_q    <= '0;
      de_q    <= '0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      se_q    <= se_d;
      de_q    <= de_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
    end
  end

  secded_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .T     (err_log_entry_t)
  ) u_log (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (log_push),
    .wdata_i (log_wdata),
    .pop_i   (log_pop),
    .rdata_o (log_head),
    .full_o  (log_full),
    .empty_o (log_empty)
  );

  assign SE_CNT    = se_q;
  assign DE_CNT    = de_q;
  assign IRQ       = irq_q;
  assign LOG_OVF   = ovf_q;
  assign LOG_VALID = ~log_empty;
  assign LOG_ADDR  = ADDR_W'(log_head.addr);
  assign LOG_DBL   = log_head.dbl;

endmodule

// File: tb/tb_secded_err_monitor.sv
// Directed bench for secded_err_monitor: queue scoreboards for the data stream and error log,
// plus a reference model of counters, overflow and interrupt.
module tb_secded_err_monitor;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LOG_DEPTH = 4;
  localparam int unsigned SE_THRESH = 8;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [ADDR_W-1:0] IN_ADDR;
  logic [71:0]       D_DATA;
  logic              ERR, S_ERR, D_ERR;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [63:0]       OUT_DATA;
  logic              OUT_POISON;
  logic [CNT_W-1:0]  SE_CNT, DE_CNT;
  logic              LOG_VALID;
  logic              LOG_READY;
  logic [ADDR_W-1:0] LOG_ADDR;
  logic              LOG_DBL, LOG_OVF, IRQ, CLR;

  always #5 CLK = ~CLK;

  secded_err_monitor #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .LOG_DEPTH (LOG_DEPTH),
    .SE_THRESH (SE_THRESH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_ADDR    (IN_ADDR),
    .D_DATA     (D_DATA),
    .ERR        (ERR),
    .S_ERR      (S_ERR),
    .D_ERR      (D_ERR),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_POISON (OUT_POISON),
    .SE_CNT     (SE_CNT),
    .DE_CNT     (DE_CNT),
    .LOG_VALID  (LOG_VALID),
    .LOG_READY  (LOG_READY),
    .LOG_ADDR   (LOG_ADDR),
    .LOG_DBL    (LOG_DBL),
    .LOG_OVF    (LOG_OVF),
    .IRQ        (IRQ),
    .CLR        (CLR)
  );

  typedef struct {
    logic [63:0] data;
    logic        poison;
  } ow_t;

  typedef struct {
    logic [31:0] addr;
    logic        dbl;
  } le_t;

  ow_t oq[$];
  le_t lq[$];
  logic [CNT_W-1:0] se_m, de_m;
  logic irq_m, ovf_m;

  int  checks = 0;
  int  passed = 0;
  int  fails  = 0;
  bit  chk_en = 1'b0;
  bit  last_acc = 1'b0;
  int  stall = 0;
  logic ordy = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_in_ready",   64'(IN_READY),   64'd1);
    check("rst_out_valid",  64'(OUT_VALID),  64'd0);
    check("rst_out_data",   OUT_DATA,        64'd0);
    check("rst_out_poison", 64'(OUT_POISON), 64'd0);
    check("rst_se_cnt",     64'(SE_CNT),     64'd0);
    check("rst_de_cnt",     64'(DE_CNT),     64'd0);
    check("rst_log_valid",  64'(LOG_VALID),  64'd0);
    check("rst_log_addr",   64'(LOG_ADDR),   64'd0);
    check("rst_log_dbl",    64'(LOG_DBL),    64'd0);
    check("rst_log_ovf",    64'(LOG_OVF),    64'd0);
    check("rst_irq",        64'(IRQ),        64'd0);
  endtask

  // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit acc, opop, lpop, lfull, irq_set, ovf_set;
    logic [CNT_W-1:0] se_b, de_b;
    ow_t w;
    le_t e;
    if (stall > 0) begin
      OUT_READY = 1'b0;
      stall--;
    end else begin
      OUT_READY = ordy;
    end
    @(negedge CLK);
    if (IN_VALID)
      assert (ERR ? (S_ERR ^ D_ERR) : !(S_ERR | D_ERR))
      else $error("illegal decoder flag combination driven");
    if (chk_en) begin
      check("in_ready",  64'(IN_READY),  64'(oq.size() != 2));
      check("out_valid", 64'(OUT_VALID), 64'(oq.size() != 0));
      if (oq.size() != 0) begin
        check("out_data",   OUT_DATA,        oq[0].data);
        check("out_poison", 64'(OUT_POISON), 64'(oq[0].poison));
      end
      check("se_cnt",    64'(SE_CNT),    64'(se_m));
      check("de_cnt",    64'(DE_CNT),    64'(de_m));
      check("irq",       64'(IRQ),       64'(irq_m));
      check("log_ovf",   64'(LOG_OVF),   64'(ovf_m));
      check("log_valid", 64'(LOG_VALID), 64'(lq.size() != 0));
      if (lq.size() != 0) begin
        check("log_addr", 64'(LOG_ADDR), 64'(lq[0].addr));
        check("log_dbl",  64'(LOG_DBL),  64'(lq[0].dbl));
      end
    end
    acc = 1'b0;
    if (RST) begin
      oq.delete();
      lq.delete();
      se_m = '0; de_m = '0; irq_m = 1'b0; ovf_m = 1'b0;
    end else begin
      acc   = IN_VALID && (oq.size() != 2);
      opop  = (oq.size() != 0) && OUT_READY;
      lpop  = (lq.size() != 0) && LOG_READY;
      lfull = (lq.size() == LOG_DEPTH);
      w.data = D_DATA[63:0];
      w.poison = D_ERR;
      e.addr = IN_ADDR;
      e.dbl = D_ERR;
      if (opop) void'(oq.pop_front());
      if (acc) oq.push_back(w);
      if (lpop) void'(lq.pop_front());
      ovf_set = 1'b0;
      if (acc && ERR) begin
        if (lfull && !lpop) ovf_set = 1'b1;
        else lq.push_back(e);
      end
      se_b = CLR ? '0 : se_m;
      de_b = CLR ? '0 : de_m;
      irq_set = acc && D_ERR;
      if (acc && S_ERR) begin
        if (int'(se_b) == SE_THRESH - 1) irq_set = 1'b1;
        se_m = (se_b == CMAX) ? CMAX : se_b + 1'b1;
      end else se_m = se_b;
      de_m = (acc && D_ERR) ? ((de_b == CMAX) ? CMAX : de_b + 1'b1) : de_b;
      irq_m = (CLR ? 1'b0 : irq_m) | irq_set;
      ovf_m = (CLR ? 1'b0 : ovf_m) | ovf_set;
    end
    last_acc = acc;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic s, input logic dd, input logic [31:0] a);
    IN_VALID = 1'b1;
    D_DATA   = {8'($urandom), d};
    ERR      = s | dd;
    S_ERR    = s;
    D_ERR    = dd;
    IN_ADDR  = a;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) break;
    end
    check("send_accepted", 64'(last_acc), 64'd1);
    IN_VALID = 1'b0;
    ERR = 1'b0; S_ERR = 1'b0; D_ERR = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_ADDR = '0; D_DATA = '0;
    ERR = 1'b0; S_ERR = 1'b0; D_ERR = 1'b0;
    OUT_READY = 1'b1; LOG_READY = 1'b0; CLR = 1'b0;
    step(); step();
    RST = 1'b0;
    chk_en = 1'b1;
    check_reset();

    // clean back-to-back stream
    for (int i = 0; i < 10; i++) send(rnd64(), 1'b0, 1'b0, 32'(i));
    step(); step();
    check("clean_se_cnt", 64'(SE_CNT), 64'd0);
    check("clean_irq",    64'(IRQ),    64'd0);

    // backpressure with an S_ERR word held upstream while IN_READY is low
    stall = 4;
    for (int i = 0; i < 6; i++) send(rnd64(), 1'(i == 2), 1'b0, 32'h50 + 32'(i));
    step(); step(); step();
    check("bp_se_once", 64'(SE_CNT), 64'd1);
    LOG_READY = 1'b1; step(); step(); LOG_READY = 1'b0;
    CLR = 1'b1; step(); CLR = 1'b0;

    // threshold, log fill and overflow
    for (int i = 0; i < 8; i++) send(rnd64(), 1'b1, 1'b0, 32'h100 + 32'(i));
    step();
    check("thr_irq",    64'(IRQ),      64'd1);
    check("thr_ovf",    64'(LOG_OVF),  64'd1);
    check("thr_head",   64'(LOG_ADDR), 64'h100);
    LOG_READY = 1'b1;
    repeat (5) step();
    LOG_READY = 1'b0;

    // double error
    CLR = 1'b1; step(); CLR = 1'b0;
    send(rnd64(), 1'b0, 1'b1, 32'hDEAD0000);
    check("de_poison",   64'(OUT_POISON), 64'd1);
    check("de_cnt",      64'(DE_CNT),     64'd1);
    check("de_irq",      64'(IRQ),        64'd1);
    check("de_log_addr", 64'(LOG_ADDR),   64'hDEAD0000);
    check("de_log_dbl",  64'(LOG_DBL),    64'd1);
    step();
    LOG_READY = 1'b1; step(); LOG_READY = 1'b0;

    // full log with push and pop in the same cycle
    for (int i = 0; i < 4; i++) send(rnd64(), 1'b1, 1'b0, 32'h200 + 32'(i));
    LOG_READY = 1'b1;
    send(rnd64(), 1'b1, 1'b0, 32'h204);
    LOG_READY = 1'b0;
    check("pp_no_ovf", 64'(LOG_OVF),  64'd0);
    check("pp_head",   64'(LOG_ADDR), 64'h201);

    // CLR coincident with an S_ERR accept
    CLR = 1'b1;
    send(rnd64(), 1'b1, 1'b0, 32'h300);
    CLR = 1'b0;
    check("clr_se_cnt", 64'(SE_CNT), 64'd1);

    // saturation
    for (int i = 0; i < 20; i++) send(rnd64(), 1'b1, 1'b0, 32'h310 + 32'(i));
    step();
    check("sat_se_cnt", 64'(SE_CNT), 64'(CMAX));

    // reset with 2 buffered words and 3 log entries
    LOG_READY = 1'b1; repeat (5) step(); LOG_READY = 1'b0;
    CLR = 1'b1; step(); CLR = 1'b0;
    send(rnd64(), 1'b1, 1'b0, 32'h3FF);
    step();
    ordy = 1'b0;
    send(rnd64(), 1'b1, 1'b0, 32'h400);
    send(rnd64(), 1'b0, 1'b1, 32'h401);
    step();
    check("pre_rst_in_ready", 64'(IN_READY), 64'd0);
    RST = 1'b1; step(); RST = 1'b0;
    ordy = 1'b1;
    check_reset();

    // fresh stream after reset
    for (int i = 0; i < 4; i++) send(rnd64(), 1'(i == 1), 1'b0, 32'h500 + 32'(i));
    step(); step();
    check("post_se_cnt",   64'(SE_CNT),   64'd1);
    check("post_log_addr", 64'(LOG_ADDR), 64'h501);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
